// File: rtl/dma_req_pkg.sv
// Shared definitions for the DMA request builder: entry layout, page size and FSM encoding.
// The entry packing helper keeps the field map in one place.
package dma_req_pkg;

    localparam int unsigned ENTRY_W    = 112;
    localparam int unsigned PAGE_BYTES = 4096;

    localparam int unsigned HOST_LSB  = 0;
    localparam int unsigned HOST_MSB  = 63;
    localparam int unsigned LOCAL_LSB = 64;
    localparam int unsigned LOCAL_MSB = 95;
    localparam int unsigned TAG_LSB   = 96;
    localparam int unsigned TAG_MSB   = 103;
    localparam int unsigned CNT_LSB   = 104;
    localparam int unsigned CNT_MSB   = 106;
    localparam int unsigned LAST_BIT  = 107;
    localparam int unsigned SEQ_LSB   = 108;
    localparam int unsigned SEQ_MSB   = 111;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [63:0] host,
        input logic [31:0] local_addr,
        input logic [7:0]  tag,
        input logic [2:0]  cnt,
        input logic        last,
        input logic [3:0]  seq
    );
        logic [ENTRY_W-1:0] e;
        e                     = '0;
        e[HOST_MSB:HOST_LSB]   = host;
        e[LOCAL_MSB:LOCAL_LSB] = local_addr;
        e[TAG_MSB:TAG_LSB]     = tag;
        e[CNT_MSB:CNT_LSB]     = cnt;
        e[LAST_BIT]            = last;
        e[SEQ_MSB:SEQ_LSB]     = seq;
        return e;
    endfunction

endpackage

// File: rtl/dma_chunk_calc.sv
// Chunk size for the next DMA entry: the smallest of the per-entry cap, the blocks left
// in the command and the blocks left before the next 4 KB host page boundary.
module dma_chunk_calc
    import dma_req_pkg::*;
#(
    parameter int unsigned MAX_CHUNK   = 4,
    parameter int unsigned BLOCK_SHIFT = 7
) (
    input  logic [11:0] host_off_i,
    input  logic [15:0] remaining_i,
    output logic [2:0]  chunk_o
);

    logic [12:0] to_boundary;
    logic [15:0] lim;

    // 13 bits so that a page-aligned offset yields the full 4096 bytes
    assign to_boundary = (13'(PAGE_BYTES) - {1'b0, host_off_i}) >> BLOCK_SHIFT;

    always_comb begin
        lim = 16'(MAX_CHUNK);
        if (remaining_i < lim) begin
            lim = remaining_i;
        end
        if ({3'b000, to_boundary} < lim) begin
            lim = {3'b000, to_boundary};
        end
        chunk_o = 3'(lim);
    end

endmodule

// File: rtl/dma_request_builder.sv
// Splits one host DMA command into page-safe chunks and pushes one entry per chunk into the
// read (SQ) or write (RQ) request FIFO, one entry per cycle unless that FIFO is full.
module dma_request_builder
    import dma_req_pkg::*;
#(
    parameter int unsigned MAX_CHUNK   = 4,
    parameter int unsigned BLOCK_BYTES = 128,
    parameter int unsigned BLOCK_SHIFT = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               CmdValid,
    output logic               CmdReady,
    input  logic               CmdDir,
    input  logic [63:0]        CmdHostAddr,
    input  logic [31:0]        CmdLocalAddr,
    input  logic [15:0]        CmdBlocks,
    input  logic [7:0]         CmdTag,
    output logic               SqDmaFifoPush,
    output logic [ENTRY_W-1:0] SqDmaFifoDataIn,
    input  logic               SqDmaFifoFull,
    output logic               RqDmaFifoPush,
    output logic [ENTRY_W-1:0] RqDmaFifoDataIn,
    input  logic               RqDmaFifoFull,
    output logic               CmdDone,
    output logic               CmdError,
    output logic               Busy
);

    localparam logic [63:0] BLK_MASK = 64'(BLOCK_BYTES - 1);

    state_e       state_q, state_d;
    logic         dir_q, dir_d;
    logic [63:0]  host_q, host_d;
    logic [31:0]  local_q, local_d;
    logic [15:0]  rem_q, rem_d;
    logic [7:0]   tag_q, tag_d;
    logic [3:0]   seq_q, seq_d;
    logic         error_q, error_d;

    logic               cmd_bad;
    logic [2:0]         chunk;
    logic [63:0]        step_bytes;
    logic               sel_full;
    logic               running;
    logic               push;
    logic               last;
    logic [ENTRY_W-1:0] entry;

    dma_chunk_calc #(
        .MAX_CHUNK   (MAX_CHUNK),
        .BLOCK_SHIFT (BLOCK_SHIFT)
    ) u_chunk_calc (
        .host_off_i  (host_q[11:0]),
        .remaining_i (rem_q),
        .chunk_o     (chunk)
    );

    assign cmd_bad    = (CmdBlocks == 16'd0)
                      || ((CmdHostAddr & BLK_MASK) != 64'd0)
                      || ((CmdLocalAddr & BLK_MASK[31:0]) != 32'd0);
    assign step_bytes = {61'd0, chunk} << BLOCK_SHIFT;
    assign running    = (state_q == StRun);
    assign sel_full   = dir_q ? RqDmaFifoFull : SqDmaFifoFull;
    assign push       = running && !sel_full;
    assign last       = (rem_q == {13'd0, chunk});
    assign entry      = pack_entry(host_q, local_q, tag_q, chunk, last, seq_q);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        host_d  = host_q;
        local_d = local_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        seq_d   = seq_q;
        error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (CmdValid) begin
                    dir_d   = CmdDir;
                    host_d  = CmdHostAddr;
                    local_d = CmdLocalAddr;
                    rem_d   = CmdBlocks;
                    tag_d   = CmdTag;
                    seq_d   = 4'd0;
                    if (cmd_bad) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // A full target FIFO freezes every register, so the same entry is retried
                if (push) begin
                    host_d  = host_q + step_bytes;
                    local_d = local_q + step_bytes[31:0];
                    rem_d   = rem_q - {13'd0, chunk};
                    seq_d   = seq_q + 4'd1;
                    if (last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            host_q  <= '0;
            local_q <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            seq_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            host_q  <= host_d;
            local_q <= local_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            seq_q   <= seq_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        CmdReady        = !running;
        Busy            = running;
        CmdDone         = push && last;
        CmdError        = error_q;
        SqDmaFifoPush   = push && !dir_q;
        RqDmaFifoPush   = push && dir_q;
        SqDmaFifoDataIn = (running && !dir_q) ? entry : '0;
        RqDmaFifoDataIn = (running && dir_q) ? entry : '0;
    end

endmodule

// File: tb/tb_dma_request_builder.sv
// Randomized bench for dma_request_builder: a queue-based chunking model predicts every FIFO
// entry, and directed cases cover page crossings, stalls, errors, address wrap and reset.
module tb_dma_request_builder;

    localparam int PAGE_B = 4096;
    localparam int BLK_B  = 128;

    logic         clock;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_dir;
    logic [63:0]  cmd_host;
    logic [31:0]  cmd_local;
    logic [15:0]  cmd_blocks;
    logic [7:0]   cmd_tag;
    logic         sq_full;
    logic         rq_full;
    bit           sel7;

    logic         d4_ready, d4_sq_push, d4_rq_push, d4_done, d4_error, d4_busy;
    logic [111:0] d4_sq_data, d4_rq_data;
    logic         d7_ready, d7_sq_push, d7_rq_push, d7_done, d7_error, d7_busy;
    logic [111:0] d7_sq_data, d7_rq_data;
    logic         m_ready, m_sq_push, m_rq_push, m_done, m_error, m_busy;
    logic [111:0] m_sq_data, m_rq_data;

    int           n_checks;
    int           n_errors;
    logic [111:0] exp_q[$];

    dma_request_builder #(.MAX_CHUNK(4), .BLOCK_BYTES(128), .BLOCK_SHIFT(7)) dut (
        .clock           (clock),
        .reset           (reset),
        .CmdValid        (cmd_valid && !sel7),
        .CmdReady        (d4_ready),
        .CmdDir          (cmd_dir),
        .CmdHostAddr     (cmd_host),
        .CmdLocalAddr    (cmd_local),
        .CmdBlocks       (cmd_blocks),
        .CmdTag          (cmd_tag),
        .SqDmaFifoPush   (d4_sq_push),
        .SqDmaFifoDataIn (d4_sq_data),
        .SqDmaFifoFull   (sq_full),
        .RqDmaFifoPush   (d4_rq_push),
        .RqDmaFifoDataIn (d4_rq_data),
        .RqDmaFifoFull   (rq_full),
        .CmdDone         (d4_done),
        .CmdError        (d4_error),
        .Busy            (d4_busy)
    );

    dma_request_builder #(.MAX_CHUNK(7), .BLOCK_BYTES(128), .BLOCK_SHIFT(7)) dut7 (
        .clock           (clock),
        .reset           (reset),
        .CmdValid        (cmd_valid && sel7),
        .CmdReady        (d7_ready),
        .CmdDir          (cmd_dir),
        .CmdHostAddr     (cmd_host),
        .CmdLocalAddr    (cmd_local),
        .CmdBlocks       (cmd_blocks),
        .CmdTag          (cmd_tag),
        .SqDmaFifoPush   (d7_sq_push),
        .SqDmaFifoDataIn (d7_sq_data),
        .SqDmaFifoFull   (sq_full),
        .RqDmaFifoPush   (d7_rq_push),
        .RqDmaFifoDataIn (d7_rq_data),
        .RqDmaFifoFull   (rq_full),
        .CmdDone         (d7_done),
        .CmdError        (d7_error),
        .Busy            (d7_busy)
    );

    always_comb begin
        m_ready   = sel7 ? d7_ready   : d4_ready;
        m_sq_push = sel7 ? d7_sq_push : d4_sq_push;
        m_rq_push = sel7 ? d7_rq_push : d4_rq_push;
        m_done    = sel7 ? d7_done    : d4_done;
        m_error   = sel7 ? d7_error   : d4_error;
        m_busy    = sel7 ? d7_busy    : d4_busy;
        m_sq_data = sel7 ? d7_sq_data : d4_sq_data;
        m_rq_data = sel7 ? d7_rq_data : d4_rq_data;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [111:0] got, input logic [111:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: walk the command in whole blocks, never past a page edge or the chunk cap
    function automatic bit model_cmd(input logic [63:0] host, input logic [31:0] loc,
                                     input int blocks, input logic [7:0] tag, input int maxc);
        int rem;
        int seq;
        int tb;
        int c;
        if (blocks == 0 || (host % BLK_B) != 0 || (loc % BLK_B) != 0) return 1'b1;
        rem = blocks;
        seq = 0;
        while (rem > 0) begin
            tb = (PAGE_B - int'(host % PAGE_B)) / BLK_B;
            c  = rem;
            if (c > maxc) c = maxc;
            if (c > tb) c = tb;
            exp_q.push_back({4'(seq), (rem == c), 3'(c), tag, loc, host});
            host = host + 64'(c * BLK_B);
            loc  = loc + 32'(c * BLK_B);
            rem  = rem - c;
            seq++;
        end
        return 1'b0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, m_ready, 1);
        check_eq({tag, "_busy"}, m_busy, 0);
        check_eq({tag, "_sq_push"}, m_sq_push, 0);
        check_eq({tag, "_rq_push"}, m_rq_push, 0);
        check_eq({tag, "_sq_data"}, m_sq_data, 0);
        check_eq({tag, "_rq_data"}, m_rq_data, 0);
        check_eq({tag, "_done"}, m_done, 0);
    endtask

    task automatic run_cmd(input logic dir, input logic [63:0] host, input logic [31:0] loc,
                           input int blocks, input logic [7:0] tag, input bit use7,
                           input int stall_pct, input logic [31:0] stall_mask,
                           output int pushes);
        bit           exp_err;
        bit           done;
        bit           stall;
        int           cyc;
        logic [111:0] e;
        logic         sel_push;
        logic [111:0] sel_data;
        exp_q.delete();
        pushes = 0;
        sel7   = use7;
        cyc    = 0;
        @(negedge clock);
        while (!m_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("ready_before_cmd", m_ready, 1);
        exp_err = model_cmd(host, loc, blocks, tag, use7 ? 7 : 4);

        @(posedge clock); #1;
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_host   = host;
        cmd_local  = loc;
        cmd_blocks = 16'(blocks);
        cmd_tag    = tag;
        sq_full    = 1'b0;
        rq_full    = 1'b0;
        @(posedge clock); #1;
        cmd_valid  = 1'b0;
        cmd_host   = {$urandom, $urandom};
        cmd_local  = $urandom;
        cmd_blocks = 16'($urandom);
        cmd_tag    = 8'($urandom);

        if (exp_err) begin
            @(negedge clock);
            check_eq("err_pulse", m_error, 1);
            check_idle_outputs("err_cycle");
            @(posedge clock); #1;
            @(negedge clock);
            check_eq("err_one_cycle", m_error, 0);
            check_eq("err_ready", m_ready, 1);
        end else begin
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 400) begin
                stall = (cyc < 32 && stall_mask[cyc]) || (int'($urandom % 100) < stall_pct);
                if (dir) begin
                    rq_full = stall;
                    sq_full = 1'($urandom);
                end else begin
                    sq_full = stall;
                    rq_full = 1'($urandom);
                end
                @(negedge clock);
                sel_push = dir ? m_rq_push : m_sq_push;
                sel_data = dir ? m_rq_data : m_sq_data;
                check_eq("run_busy", m_busy, 1);
                check_eq("run_ready", m_ready, 0);
                check_eq("other_push", dir ? m_sq_push : m_rq_push, 0);
                check_eq("other_data", dir ? m_sq_data : m_rq_data, 0);
                if (stall) begin
                    check_eq("stall_push", sel_push, 0);
                    check_eq("stall_done", m_done, 0);
                end else begin
                    check_eq("push", sel_push, 1);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    check_eq("entry", sel_data, e);
                    check_eq("done", m_done, e[107]);
                    pushes++;
                    done = e[107];
                end
                @(posedge clock); #1;
                cyc++;
            end
            check_eq("cmd_completed", done, 1);
            check_eq("entries_left", exp_q.size(), 0);
            sq_full = 1'b0;
            rq_full = 1'b0;
            @(negedge clock);
            check_idle_outputs("after_done");
        end
    endtask

    initial begin
        int           n;
        logic [63:0]  r_host;
        logic [31:0]  r_local;
        int           r_blocks;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_host   = '0;
        cmd_local  = '0;
        cmd_blocks = '0;
        cmd_tag    = '0;
        sq_full    = 1'b0;
        rq_full    = 1'b0;
        sel7       = 1'b0;
        #12;
        check_idle_outputs("reset");
        check_eq("reset_error", m_error, 0);
        @(negedge clock);
        reset = 1'b1;

        run_cmd(1'b0, 64'h1000, 32'h0, 10, 8'h5A, 1'b0, 0, 32'h0, n);
        check_eq("read10_pushes", n, 3);
        run_cmd(1'b1, 64'h1F80, 32'h100, 5, 8'h11, 1'b0, 0, 32'h0, n);
        check_eq("page_cross_pushes", n, 2);
        run_cmd(1'b1, 64'h4000, 32'h800, 8, 8'h22, 1'b0, 0, 32'b1110, n);
        check_eq("stall_pushes", n, 2);
        run_cmd(1'b0, 64'h2000, 32'h0, 0, 8'h33, 1'b0, 0, 32'h0, n);
        check_eq("zero_len_pushes", n, 0);
        run_cmd(1'b1, 64'h1040, 32'h0, 4, 8'h44, 1'b0, 0, 32'h0, n);
        check_eq("misalign_pushes", n, 0);
        run_cmd(1'b0, 64'hFFFF_FFFF_FFFF_FF80, 32'h80, 2, 8'h55, 1'b0, 0, 32'h0, n);
        check_eq("wrap_pushes", n, 2);
        run_cmd(1'b1, 64'h0, 32'h0, 20, 8'h66, 1'b1, 0, 32'h0, n);
        check_eq("max7_pushes", n, 3);

        // Reset in the middle of a command
        sel7 = 1'b0;
        @(posedge clock); #1;
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b0;
        cmd_host   = 64'h1000;
        cmd_local  = 32'h0;
        cmd_blocks = 16'd10;
        cmd_tag    = 8'h77;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(negedge clock);
        check_eq("rst_first_push", m_sq_push, 1);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("rst_second_push", m_sq_push, 1);
        #1 reset = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        check_eq("mid_reset_error", m_error, 0);
        @(posedge clock); #1;
        check_eq("mid_reset_held_busy", m_busy, 0);
        @(negedge clock);
        reset = 1'b1;
        run_cmd(1'b0, 64'h3000, 32'h80, 1, 8'h88, 1'b0, 0, 32'h0, n);
        check_eq("post_reset_pushes", n, 1);

        for (int i = 0; i < 40; i++) begin
            r_host = {$urandom, $urandom};
            r_host[11:0] = 12'(($urandom % 32) * BLK_B);
            if ($urandom % 10 == 0) r_host[6] = 1'b1;
            r_local = $urandom & ~32'h7F;
            if ($urandom % 15 == 0) r_local[4] = 1'b1;
            r_blocks = ($urandom % 12 == 0) ? 0 : 1 + int'($urandom % 40);
            run_cmd(1'($urandom), r_host, r_local, r_blocks, 8'($urandom), 1'($urandom),
                    25, 32'h0, n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
